// File: rtl/oam_dma_pkg.sv
// ============================================================================
// oam_dma_pkg -- state encoding and default addresses for the OAM DMA engine.
// Optional feature macro: OAM_DMA_ALIGN_EN (adds the ALIGN state).
// Revision: 1.0
// ============================================================================
`default_nettype none

package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;
`endif

  function automatic logic is_dma_trigger(input logic [15:0] addr,
                                          input logic        addr_valid,
                                          input logic        write,
                                          input logic [15:0] reg_addr);
    return addr_valid && write && (addr == reg_addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
// oam_dma -- CPU-halting 256-byte page copy into the OAM data port.
// Optional feature macro: OAM_DMA_ALIGN_EN (odd-cycle ALIGN tick via parity).
// Revision: 1.0
// ============================================================================
`default_nettype none

module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REGISTER_ADDRESS = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDRESS     = OAM_DATA_ADDR_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        tick_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_write_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic        cpu_halt_o,
  output logic [15:0] bus_address_o,
  output logic        bus_address_valid_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_write_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_data_valid_i,
  output logic        busy_o
);

  state_e     state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] byte_q,  byte_d;
  logic       trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic       parity_q;
`endif

  assign trigger = is_dma_trigger(cpu_address_i, cpu_address_valid_i,
                                  cpu_write_i, DMA_REGISTER_ADDRESS);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      byte_q   <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
      parity_q <= 1'b0;
`endif
    end else if (tick_i) begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      byte_q   <= byte_d;
`ifdef OAM_DMA_ALIGN_EN
      parity_q <= ~parity_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    byte_d  = byte_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          page_d  = cpu_data_i;
          index_d = 8'h00;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // Parity tracks the CPU get/put phase; odd phase costs one extra tick.
        state_d = parity_q ? ST_ALIGN : ST_READ;
`else
        state_d = ST_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ST_ALIGN: begin
        state_d = ST_READ;
      end
`endif
      ST_READ: begin
        if (bus_data_valid_i) begin
          byte_d  = bus_data_i;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        index_d = index_q + 8'd1;
        state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus mux: transparent to the CPU while idle, owned by the engine otherwise.
  always_comb begin
    cpu_data_o          = 8'h00;
    cpu_data_valid_o    = 1'b0;
    cpu_halt_o          = 1'b1;
    bus_address_o       = 16'h0000;
    bus_address_valid_o = 1'b0;
    bus_data_o          = 8'h00;
    bus_write_o         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_data_o          = bus_data_i;
        cpu_data_valid_o    = bus_data_valid_i;
        cpu_halt_o          = 1'b0;
        bus_address_o       = cpu_address_i;
        bus_address_valid_o = cpu_address_valid_i;
        bus_data_o          = cpu_data_i;
        bus_write_o         = cpu_write_i;
      end
      ST_READ: begin
        bus_address_o       = {page_q, index_q};
        bus_address_valid_o = 1'b1;
      end
      ST_WRITE: begin
        bus_address_o       = OAM_DATA_ADDRESS;
        bus_address_valid_o = 1'b1;
        bus_data_o          = byte_q;
        bus_write_o         = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
// tb_oam_dma -- scoreboard bench for oam_dma (tick every other clock).
// Honours OAM_DMA_ALIGN_EN when computing expected halt lengths.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_oam_dma;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        tick_i = 1'b0;
  logic [15:0] cpu_address_i = 16'h0000;
  logic        cpu_address_valid_i = 1'b0;
  logic [7:0]  cpu_data_i = 8'h00;
  logic        cpu_write_i = 1'b0;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic        cpu_halt_o;
  logic [15:0] bus_address_o;
  logic        bus_address_valid_o;
  logic [7:0]  bus_data_o;
  logic        bus_write_o;
  logic [7:0]  bus_data_i;
  logic        bus_data_valid_i = 1'b1;
  logic        busy_o;

  oam_dma dut (
    .clock_i             (clock_i),
    .reset_ni            (reset_ni),
    .tick_i              (tick_i),
    .cpu_address_i       (cpu_address_i),
    .cpu_address_valid_i (cpu_address_valid_i),
    .cpu_data_i          (cpu_data_i),
    .cpu_write_i         (cpu_write_i),
    .cpu_data_o          (cpu_data_o),
    .cpu_data_valid_o    (cpu_data_valid_o),
    .cpu_halt_o          (cpu_halt_o),
    .bus_address_o       (bus_address_o),
    .bus_address_valid_o (bus_address_valid_o),
    .bus_data_o          (bus_data_o),
    .bus_write_o         (bus_write_o),
    .bus_data_i          (bus_data_i),
    .bus_data_valid_i    (bus_data_valid_i),
    .busy_o              (busy_o)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int          len_q[$];

  logic [15:0] stall_addr = 16'h0000;
  int          stall_left = 0;
  int          stall_seen = 0;

  int tick_k = 0;
  bit in_xfer = 1'b0;
  int halt_cnt = 0;
  int align_bit = 0;

  always #5 clock_i = ~clock_i;

  initial forever begin
    @(posedge clock_i);
    #1 tick_i = ~tick_i;
  end

  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  always @* bus_data_i = mem(bus_address_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait-state responder: withholds bus_data_valid_i on reads of stall_addr.
  initial forever begin
    @(posedge clock_i);
    if (tick_i && !bus_data_valid_i && stall_left > 0) stall_left--;
    #3;
    if (tick_i && busy_o && bus_address_valid_o && !bus_write_o &&
        stall_left > 0 && bus_address_o == stall_addr)
      bus_data_valid_i = 1'b0;
    else
      bus_data_valid_i = 1'b1;
  end

  // Monitor: observes each tick mid-cycle and checks against the queues.
  always @(negedge clock_i) begin
    if (!reset_ni) begin
      tick_k  = 0;
      in_xfer = 1'b0;
    end else if (tick_i) begin
      if (busy_o) begin
        if (!in_xfer) begin
          in_xfer  = 1'b1;
          halt_cnt = 0;
`ifdef OAM_DMA_ALIGN_EN
          align_bit = tick_k % 2;
`else
          align_bit = 0;
`endif
        end
        if (cpu_halt_o) halt_cnt++;
        if (bus_address_valid_o && bus_write_o) begin
          if (wr_q.size() == 0) chk("unexpected_write", {16'h0, bus_address_o}, 32'hFFFF_FFFF);
          else begin
            chk("write_addr", {16'h0, bus_address_o}, 32'h2004);
            chk("write_data", {24'h0, bus_data_o}, {24'h0, wr_q.pop_front()});
          end
        end else if (bus_address_valid_o && !bus_data_valid_i) begin
          stall_seen++;
          chk("stall_addr_hold", {16'h0, bus_address_o}, {16'h0, stall_addr});
        end else if (bus_address_valid_o) begin
          if (rd_q.size() == 0) chk("unexpected_read", {16'h0, bus_address_o}, 32'hFFFF_FFFF);
          else chk("read_addr", {16'h0, bus_address_o}, {16'h0, rd_q.pop_front()});
        end
      end else if (in_xfer) begin
        in_xfer = 1'b0;
        if (len_q.size() == 0) chk("unexpected_xfer_end", halt_cnt, 0);
        else chk("halt_ticks", halt_cnt, len_q.pop_front() + align_bit);
      end
      tick_k++;
    end
  end

  task automatic push_xfer(input logic [7:0] page, input int extra);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, i[7:0]};
      rd_q.push_back(a);
      wr_q.push_back(mem(a));
    end
    len_q.push_back(513 + extra);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    do begin
      @(posedge clock_i);
      #2;
    end while (!tick_i);
    cpu_address_i = a;
    cpu_data_i = d;
    cpu_address_valid_i = 1'b1;
    cpu_write_i = 1'b1;
    #1;
    if (!busy_o) begin
      chk("pt_addr", {16'h0, bus_address_o}, {16'h0, a});
      chk("pt_data", {24'h0, bus_data_o}, {24'h0, d});
      chk("pt_ctrl", {30'h0, bus_address_valid_o, bus_write_o}, 32'h3);
      chk("pt_halt", {31'h0, cpu_halt_o}, 32'h0);
    end else begin
      chk("busy_halt", {31'h0, cpu_halt_o}, 32'h1);
      chk("busy_cpu_valid", {31'h0, cpu_data_valid_o}, 32'h0);
    end
    @(posedge clock_i);
    #2;
    cpu_address_valid_i = 1'b0;
    cpu_write_i = 1'b0;
    cpu_address_i = 16'h0000;
    cpu_data_i = 8'h00;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clock_i);
      #1;
      if (!busy_o && rd_q.size() == 0 && wr_q.size() == 0 && len_q.size() == 0) done = 1'b1;
    end
    chk("xfer_complete", {31'h0, done}, 32'h1);
    rd_q.delete();
    wr_q.delete();
    len_q.delete();
  endtask

  initial begin
    bit found;
    cpu_address_i = 16'h1234;
    cpu_data_i = 8'h99;
    cpu_address_valid_i = 1'b1;
    repeat (4) @(posedge clock_i);
    #2;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_halt", {31'h0, cpu_halt_o}, 32'h0);
    chk("rst_pt_addr", {16'h0, bus_address_o}, 32'h1234);
    chk("rst_pt_data", {24'h0, bus_data_o}, 32'h99);
    chk("rst_pt_rdata", {24'h0, cpu_data_o}, {24'h0, mem(16'h1234)});
    chk("rst_pt_rvalid", {31'h0, cpu_data_valid_o}, 32'h1);
    cpu_address_i = 16'h0000;
    cpu_data_i = 8'h00;
    cpu_address_valid_i = 1'b0;
    @(posedge clock_i);
    #1 reset_ni = 1'b1;

    // Basic page 02 copy, zero-wait reads
    push_xfer(8'h02, 0);
    cpu_wr(16'h4014, 8'h02);
    wait_done();

    // Three wait states on the read of 0205
    stall_addr = 16'h0205;
    stall_left = 3;
    stall_seen = 0;
    push_xfer(8'h02, 3);
    cpu_wr(16'h4014, 8'h02);
    wait_done();
    chk("stall_ticks", stall_seen, 3);

    // Retrigger while busy is ignored; non-matching address does not trigger
    push_xfer(8'h11, 0);
    cpu_wr(16'h4014, 8'h11);
    repeat (40) @(posedge clock_i);
    cpu_wr(16'h4014, 8'h77);
    wait_done();
    cpu_wr(16'h4015, 8'hAB);
    repeat (6) @(posedge clock_i);
    #1;
    chk("no_trigger_4015", {31'h0, busy_o}, 32'h0);

    // Reset in the middle of the transfer, at index 40
    push_xfer(8'h05, 0);
    cpu_wr(16'h4014, 8'h05);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(posedge clock_i);
      #1;
      if (busy_o && bus_address_valid_o && !bus_write_o && bus_address_o == 16'h0540) found = 1'b1;
    end
    chk("reach_index_40", {31'h0, found}, 32'h1);
    reset_ni = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    chk("midrst_halt", {31'h0, cpu_halt_o}, 32'h0);
    chk("midrst_bus", {15'h0, bus_address_o, bus_write_o}, 32'h0);
    chk("midrst_rd_left", rd_q.size(), 192);
    chk("midrst_wr_left", wr_q.size(), 192);
    rd_q.delete();
    wr_q.delete();
    len_q.delete();
    repeat (3) @(posedge clock_i);
    #1 reset_ni = 1'b1;
    push_xfer(8'h05, 0);
    cpu_wr(16'h4014, 8'h05);
    wait_done();

    // Top page: last read is FFFF, no wrap to 0000
    push_xfer(8'hFF, 0);
    cpu_wr(16'h4014, 8'hFF);
    wait_done();
    repeat (4) @(posedge clock_i);
    #1;
    chk("end_idle", {31'h0, busy_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
